reg_dump_reader: RTL and testbench
==================================

// Module: reg_dump_reader
// PURPOSE
//  Debug read-out client for the 32x32 register file: on a start pulse it walks a register
//  address range over one register-file read port, one address at a time. Each value is
//  sent on a valid/ready stream tagged with its address. Sits beside the datapath on a
//  spare read port; used for state dumps by the debug block and by testbenches.
// PARAMETERS
//  ADDR_W   5   register address width (register file depth = 2**ADDR_W)
//  DATA_W   32  register data width
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rst         in   1       synchronous, active-high reset
//  start       in   1       one-cycle request to begin a dump; sampled only in IDLE
//  first_addr  in   ADDR_W  first register of range; latched when start is accepted
//  last_addr   in   ADDR_W  last register of range, inclusive; latched when start is accepted
//  busy        out  1       high in any state other than IDLE
//  done        out  1       one-cycle pulse when the dump completes
//  rf_rd_addr  out  ADDR_W  register file read address
//  rf_rd_data  in   DATA_W  register file read data; combinational from rf_rd_addr; reg 0 reads 0
//  out_valid   out  1       out_addr, out_data and out_last are valid
//  out_ready   in   1       sink accepts the beat
//  out_addr    out  ADDR_W  register index of the current beat
//  out_data    out  DATA_W  register value of the current beat
//  out_last    out  1       current beat is the last register of the range
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - state = IDLE; busy, done, out_valid and out_last = 0; out_addr, out_data and rf_rd_addr = 0.
//   - Reset takes priority in every state, including mid-dump: the next cycle is IDLE with
//     out_valid = 0 and no done pulse.
//  FSM states: IDLE, READ, SEND, FINISH. The cur register holds the current address.
//   - IDLE: rf_rd_addr = 0.
//     - start=1 and first_addr <= last_addr: latch first/last, cur <= first_addr, go to READ.
//     - start=1 and first_addr > last_addr: empty range; go to FINISH with no beats.
//     - start=0: stay in IDLE.
//   - READ: rf_rd_addr = cur. At the posedge: out_data <= rf_rd_data, out_addr <= cur,
//     out_last <= (cur == last), out_valid <= 1, go to SEND.
//   - SEND: out_valid = 1. out_addr, out_data and out_last stay stable until the handshake
//     (out_valid & out_ready at a posedge).
//     - Handshake with out_last=1: out_valid <= 0, go to FINISH.
//     - Handshake with out_last=0: out_valid <= 0, cur <= cur+1, go to READ.
//     - No handshake: stay in SEND.
//   - FINISH: done = 1 for exactly this one cycle, then go to IDLE.
//  Rules
//   - start outside IDLE is ignored; it is not queued.
//   - cur never wraps: it increments only when cur != last, so last_addr = 2**ADDR_W-1 is legal.
//   - Latency: first beat valid 2 cycles after start is accepted. Peak throughput is
//     1 beat per 2 cycles. An N-register dump with out_ready held high has done high
//     2N+1 cycles after the start cycle.
//   - busy = (state != IDLE), including FINISH.
//   - The block never writes the register file. Writes by the datapath during a dump are
//     allowed; the value read is whatever the file holds in the READ cycle.
// TESTING
//  1 rst=1 for 2 cycles with out_ready=1 -> busy=0, done=0, out_valid=0, rf_rd_addr=0.
//    Then rst=0 with start held low for 5 cycles -> outputs unchanged.
//  2 Preload reg[k]=0x01010101*k, then start with first=0, last=31, out_ready=1
//    -> exactly 32 beats, addr 0..31, data[0]=0 and data[31]=0x1F1F1F1F.
//    out_last is high only on addr 31; done pulses once, 65 cycles after start.
//  3 Range 4..6 with out_ready low for 3 cycles on each beat -> each beat is held stable
//    while stalled. Beats are (4,0x04040404), (5,0x05050505), (6,0x06060606), then one done pulse.
//  4 first=last=7 -> one beat (7,0x07070707) with out_last=1. first=9, last=3 -> no beats,
//    and done pulses on the cycle after start.
//  5 A start pulse during a 0..31 dump is ignored, and the dump stays intact.
//    rst=1 while in SEND at addr 10 -> out_valid=0 the next cycle with no done pulse.
//    A new start then dumps 2..3 correctly.

Source files
------------

// File: rtl/reg_dump_reader.sv
// Debug read-out client: walks a register address range over one register-file read
// port and streams each value, tagged with its address, on a valid/ready interface.
module reg_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] cur_r;
    logic [ADDR_W-1:0] last_r;

    // Dump sequencer; rf_rd_addr is loaded one cycle ahead so it equals cur during READ.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cur_r      <= '0;
            last_r     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rf_rd_addr <= '0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            out_last   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    rf_rd_addr <= '0;
                    if (start) begin
                        busy <= 1'b1;
                        if (first_addr <= last_addr) begin
                            cur_r      <= first_addr;
                            last_r     <= last_addr;
                            rf_rd_addr <= first_addr;
                            state_r    <= READ;
                        end else begin
                            done    <= 1'b1;
                            state_r <= FINISH;
                        end
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    out_data   <= rf_rd_data;
                    out_addr   <= cur_r;
                    out_last   <= (cur_r == last_r);
                    out_valid  <= 1'b1;
                    rf_rd_addr <= '0;
                    state_r    <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            done    <= 1'b1;
                            state_r <= FINISH;
                        end else begin
                            // cur only advances below last, so it can never wrap
                            cur_r      <= cur_r + ADDR_W'(1);
                            rf_rd_addr <= cur_r + ADDR_W'(1);
                            state_r    <= READ;
                        end
                    end else begin
                        state_r <= SEND;
                    end
                end
                FINISH: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy       <= 1'b0;
                    out_valid  <= 1'b0;
                    rf_rd_addr <= '0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader with a behavioural 32x32 register file beside it.
module tb_reg_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic        busy;
    logic        done;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;

    logic [31:0] rf [32];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rf_rd_data = (rf_rd_addr == 5'd0) ? 32'd0 : rf[rf_rd_addr];

    reg_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
        .busy(busy), .done(done), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_last(out_last)
    );

    function automatic logic [31:0] exp_data(input int a);
        return (a == 0) ? 32'd0 : 32'(32'h01010101 * a);
    endfunction

    // Runs one dump and checks every beat, stall stability, beat count and done timing.
    task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int stall,
                           input int inject_t, input string name);
        int n_exp, e, beats, dones, done_t, stall_left;
        logic new_beat, h_last;
        logic [4:0] h_addr;
        logic [31:0] h_data;
        n_exp = (f <= l) ? (int'(l) - int'(f) + 1) : 0;
        @(negedge clk);
        start = 1'b1; first_addr = f; last_addr = l; out_ready = 1'b1;
        e = int'(f); beats = 0; dones = 0; done_t = -1; new_beat = 1'b1; stall_left = 0;
        for (int t = 1; t <= 400 && dones == 0; t++) begin
            @(negedge clk);
            start = (inject_t > 0 && t == inject_t);
            if (start) begin first_addr = 5'd2; last_addr = 5'd3; end
            if (t == 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_after_start: got %b want 1", name, busy); end
            end
            if (out_valid === 1'b1) begin
                if (new_beat) begin
                    n_cmp++;
                    if (out_addr !== 5'(e) || out_data !== exp_data(e) || out_last !== (e == int'(l))) begin
                        n_err++;
                        $display("FAIL %s beat: got addr=%0d data=%h last=%b want addr=%0d data=%h last=%b",
                                 name, out_addr, out_data, out_last, e, exp_data(e), (e == int'(l)));
                    end
                    h_addr = out_addr; h_data = out_data; h_last = out_last;
                    stall_left = stall; new_beat = 1'b0;
                end else begin
                    n_cmp++;
                    if (out_addr !== h_addr || out_data !== h_data || out_last !== h_last) begin
                        n_err++;
                        $display("FAIL %s stall_stable: got addr=%0d data=%h last=%b want addr=%0d data=%h last=%b",
                                 name, out_addr, out_data, out_last, h_addr, h_data, h_last);
                    end
                end
                if (stall_left > 0) begin
                    out_ready = 1'b0; stall_left--;
                end else begin
                    out_ready = 1'b1; new_beat = 1'b1; e++; beats++;
                end
            end
            if (done === 1'b1) begin dones++; done_t = t; end
        end
        start = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (dones != 1) begin n_err++; $display("FAIL %s done_seen: got %0d want 1 (timeout)", name, dones); end
        n_cmp++;
        if (beats != n_exp) begin n_err++; $display("FAIL %s beat_count: got %0d want %0d", name, beats, n_exp); end
        n_cmp++;
        if (done_t != n_exp * (stall + 2) + 1) begin
            n_err++; $display("FAIL %s done_time: got %0d want %0d", name, done_t, n_exp * (stall + 2) + 1);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL %s after_done: got done=%b busy=%b valid=%b want 0 0 0", name, done, busy, out_valid);
        end
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || rf_rd_addr !== 5'd0 ||
            out_last !== 1'b0 || out_addr !== 5'd0 || out_data !== 32'd0) begin
            n_err++;
            $display("FAIL %s: got busy=%b done=%b valid=%b rd_addr=%0d last=%b addr=%0d data=%h want all 0",
                     name, busy, done, out_valid, rf_rd_addr, out_last, out_addr, out_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset_state");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle("idle_hold");
        end
    endtask

    task automatic test_full_dump();
        do_dump(5'd0, 5'd31, 0, 0, "full_dump");
    endtask

    task automatic test_stall();
        do_dump(5'd4, 5'd6, 3, 0, "stall_dump");
    endtask

    task automatic test_single_and_empty();
        do_dump(5'd7, 5'd7, 0, 0, "single_dump");
        do_dump(5'd9, 5'd3, 0, 0, "empty_dump");
    endtask

    task automatic test_ignore_start();
        do_dump(5'd0, 5'd31, 0, 7, "start_ignored");
    endtask

    task automatic test_reset_mid_dump();
        bit found;
        found = 1'b0;
        @(negedge clk);
        start = 1'b1; first_addr = 5'd0; last_addr = 5'd31; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (out_valid === 1'b1 && out_addr === 5'd10) found = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL reach_addr10: got not reached want reached"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_dump: got valid=%b done=%b busy=%b want 0 0 0", out_valid, done, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_no_done: got done=%b valid=%b want 0 0", done, out_valid);
        end
        do_dump(5'd2, 5'd3, 0, 0, "dump_after_reset");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; first_addr = 5'd0; last_addr = 5'd0; out_ready = 1'b1;
        for (int k = 0; k < 32; k++) rf[k] = 32'(32'h01010101 * k);
        test_reset();
        test_full_dump();
        test_stall();
        test_single_and_empty();
        test_ignore_start();
        test_reset_mid_dump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
